c4_drop_controller: RTL

//  Sequencer for the state-machine port of the 7x6 Connect 4 board RAM (2-bit cells, 6-bit address).
//  On a drop request it probes the chosen column bottom-up through the read port.
//  It writes the player's piece into the lowest empty cell, or reports the column full.
//  It also performs a full-board clear on request. The game FSM calls it instead of addressing the RAM directly.

---
 rtl/c4_drop_controller_if.sv | 41 ++++
 rtl/c4_drop_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/c4_drop_controller_if.sv
// ---------------------------------------------------------------------------
// c4_drop_controller_if : request/response and board-RAM signals of the drop
// controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface c4_drop_controller_if #(
  parameter int AW = 6
);
  logic          req;
  logic [2:0]    req_col;
  logic [1:0]    req_player;
  logic          clear_req;
  logic          busy;
  logic          done;
  logic          full;
  logic          err;
  logic [2:0]    land_row;
  logic [AW-1:0] read_addr;
  logic [1:0]    read_data;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [1:0]    write_data;
  logic          anim_valid;
  logic [2:0]    anim_row;

  // slave = the controller; master = its environment (game FSM plus board RAM)
  modport slave (
    input  req, req_col, req_player, clear_req, read_data,
    output busy, done, full, err, land_row, read_addr,
           write_en, write_addr, write_data, anim_valid, anim_row
  );

  modport master (
    output req, req_col, req_player, clear_req, read_data,
    input  busy, done, full, err, land_row, read_addr,
           write_en, write_addr, write_data, anim_valid, anim_row
  );
endinterface

`default_nettype wire

// File: rtl/c4_drop_controller.sv
// ---------------------------------------------------------------------------
// c4_drop_controller : drop/clear sequencer for the Connect 4 board RAM.
// Optional drop animation enabled by defining C4_DROP_ANIM_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module c4_drop_controller #(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int AW         = 6,
  parameter int RD_LAT     = 1,
  parameter int FALL_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  c4_drop_controller_if.slave bus
);

  localparam int            CW        = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [2:0]    LAST_ROW  = 3'(ROWS - 1);
  localparam logic [2:0]    LAST_COL  = 3'(COLS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(RD_LAT);

  if ((ROWS * COLS > 2 ** AW) || (ROWS > 8) || (COLS > 8) || (FALL_TICKS < 1)) begin : g_bad_cfg
    $error("c4_drop_controller: unsupported board geometry or FALL_TICKS");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
`ifdef C4_DROP_ANIM_EN
    S_ANIM  = 3'd5,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [1:0]    player_q, player_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic [2:0]    land_row_q, land_row_d;
  logic [AW-1:0] read_addr_q, read_addr_d;
  logic          write_en_q, write_en_d;
  logic [AW-1:0] write_addr_q, write_addr_d;
  logic [1:0]    write_data_q, write_data_d;

`ifdef C4_DROP_ANIM_EN
  localparam int            TW        = (FALL_TICKS < 2) ? 1 : $clog2(FALL_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(FALL_TICKS - 1);
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    anim_row_q, anim_row_d;
  logic          anim_valid_q, anim_valid_d;
`endif

  function automatic logic [AW-1:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    player_d     = player_q;
    cnt_d        = cnt_q;
    land_row_d   = land_row_q;
    full_d       = 1'b0;
    err_d        = 1'b0;
    read_addr_d  = '0;
    write_en_d   = 1'b0;
    write_addr_d = '0;
    write_data_d = 2'b00;
`ifdef C4_DROP_ANIM_EN
    tick_d       = tick_q;
    anim_row_d   = anim_row_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d    = S_CLEAR;
          write_en_d = 1'b1;
        end else if (bus.req) begin
          col_d    = bus.req_col;
          player_d = bus.req_player;
          if ((bus.req_col > LAST_COL) || (bus.req_player == 2'b00) ||
              (bus.req_player == 2'b11)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = S_READ;
            row_d       = LAST_ROW;
            cnt_d       = '0;
            read_addr_d = cell_addr(LAST_ROW, bus.req_col);
          end
        end
      end
      S_READ: begin
        read_addr_d = read_addr_q;
        if (cnt_q == CNT_LAST) begin
          if (bus.read_data == 2'b00) begin
            land_row_d   = row_q;
            read_addr_d  = '0;
`ifdef C4_DROP_ANIM_EN
            state_d      = S_ANIM;
            tick_d       = '0;
            anim_row_d   = 3'd0;
`else
            state_d      = S_WRITE;
            write_en_d   = 1'b1;
            write_addr_d = cell_addr(row_q, col_q);
            write_data_d = player_q;
`endif
          end else if (row_q != 3'd0) begin
            row_d       = row_q - 3'd1;
            cnt_d       = '0;
            read_addr_d = cell_addr(row_q - 3'd1, col_q);
          end else begin
            state_d     = S_DONE;
            full_d      = 1'b1;
            read_addr_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef C4_DROP_ANIM_EN
      S_ANIM: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (anim_row_q == land_row_q) begin
            state_d      = S_WRITE;
            write_en_d   = 1'b1;
            write_addr_d = cell_addr(land_row_q, col_q);
            write_data_d = player_q;
          end else begin
            anim_row_d = anim_row_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      S_WRITE: state_d = S_DONE;
      // write_addr_q doubles as the sweep pointer while clearing
      S_CLEAR: begin
        if (write_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          write_en_d   = 1'b1;
          write_addr_d = write_addr_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
`ifdef C4_DROP_ANIM_EN
    anim_valid_d = (state_d == S_ANIM);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      player_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      land_row_q   <= '0;
      read_addr_q  <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
`ifdef C4_DROP_ANIM_EN
      tick_q       <= '0;
      anim_row_q   <= '0;
      anim_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      player_q     <= player_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      full_q       <= full_d;
      err_q        <= err_d;
      land_row_q   <= land_row_d;
      read_addr_q  <= read_addr_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
`ifdef C4_DROP_ANIM_EN
      tick_q       <= tick_d;
      anim_row_q   <= anim_row_d;
      anim_valid_q <= anim_valid_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;
  assign bus.land_row   = land_row_q;
  assign bus.read_addr  = read_addr_q;
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
`ifdef C4_DROP_ANIM_EN
  assign bus.anim_valid = anim_valid_q;
  assign bus.anim_row   = anim_row_q;
`else
  assign bus.anim_valid = 1'b0;
  assign bus.anim_row   = 3'd0;
`endif

endmodule

`default_nettype wire
